// File: rtl/change_dispenser_if.sv
// Handshake and status bundle between the ticket machine / coin mechanism and
// the change dispenser.
interface change_dispenser_if #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 8
);
   logic             start;
   logic [WIDTH-1:0] change;
   logic             coin_ack;
   logic             refill;
   logic             coin_valid;
   logic [7:0]       coin_value;
   logic [WIDTH-1:0] remaining;
   logic             busy;
   logic             done;
   logic             short;
   logic [CNT_W-1:0] inv_50;
   logic [CNT_W-1:0] inv_10;
   logic [CNT_W-1:0] inv_5;
   logic [CNT_W-1:0] inv_1;

   modport master (
      output start, change, coin_ack, refill,
      input  coin_valid, coin_value, remaining, busy, done, short,
             inv_50, inv_10, inv_5, inv_1
   );

   modport slave (
      input  start, change, coin_ack, refill,
      output coin_valid, coin_value, remaining, busy, done, short,
             inv_50, inv_10, inv_5, inv_1
   );
endinterface

// File: rtl/change_dispenser.sv
// Greedy 50/10/5/1 change payout, one coin per valid/ack handshake, with a
// per-denomination inventory that can be refilled while idle.
module change_dispenser #(
   parameter int WIDTH   = 32,
   parameter int CNT_W   = 8,
   parameter int INIT_50 = 8,
   parameter int INIT_10 = 20,
   parameter int INIT_5  = 20,
   parameter int INIT_1  = 50
) (
   input  logic              clk,
   input  logic              reset,
   change_dispenser_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_SELECT   = 3'd1,
      S_DISPENSE = 3'd2,
      S_DONE     = 3'd3,
      S_SHORT    = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] remaining_q, remaining_d;
   logic             coin_valid_q, coin_valid_d;
   logic [7:0]       coin_value_q, coin_value_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             short_q, short_d;
   logic [CNT_W-1:0] inv_50_q, inv_50_d;
   logic [CNT_W-1:0] inv_10_q, inv_10_d;
   logic [CNT_W-1:0] inv_5_q, inv_5_d;
   logic [CNT_W-1:0] inv_1_q, inv_1_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         remaining_q  <= '0;
         coin_valid_q <= 1'b0;
         coin_value_q <= 8'd0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         short_q      <= 1'b0;
         inv_50_q     <= CNT_W'(INIT_50);
         inv_10_q     <= CNT_W'(INIT_10);
         inv_5_q      <= CNT_W'(INIT_5);
         inv_1_q      <= CNT_W'(INIT_1);
      end else begin
         state_q      <= state_d;
         remaining_q  <= remaining_d;
         coin_valid_q <= coin_valid_d;
         coin_value_q <= coin_value_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         short_q      <= short_d;
         inv_50_q     <= inv_50_d;
         inv_10_q     <= inv_10_d;
         inv_5_q      <= inv_5_d;
         inv_1_q      <= inv_1_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      remaining_d  = remaining_q;
      coin_valid_d = coin_valid_q;
      coin_value_d = coin_value_q;
      inv_50_d     = inv_50_q;
      inv_10_d     = inv_10_q;
      inv_5_d      = inv_5_q;
      inv_1_d      = inv_1_q;

      case (state_q)
         S_IDLE: begin
            // start takes priority; a simultaneous refill is simply dropped
            if (bus.start) begin
               remaining_d = bus.change;
               if (bus.change == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_SELECT;
               end
            end else if (bus.refill) begin
               inv_50_d = CNT_W'(INIT_50);
               inv_10_d = CNT_W'(INIT_10);
               inv_5_d  = CNT_W'(INIT_5);
               inv_1_d  = CNT_W'(INIT_1);
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SELECT: begin
            state_d      = S_DISPENSE;
            coin_valid_d = 1'b1;
            if (remaining_q >= WIDTH'(32'd50) && inv_50_q != '0) begin
               coin_value_d = 8'd50;
            end else if (remaining_q >= WIDTH'(32'd10) && inv_10_q != '0) begin
               coin_value_d = 8'd10;
            end else if (remaining_q >= WIDTH'(32'd5) && inv_5_q != '0) begin
               coin_value_d = 8'd5;
            end else if (remaining_q >= WIDTH'(32'd1) && inv_1_q != '0) begin
               coin_value_d = 8'd1;
            end else begin
               state_d      = S_SHORT;
               coin_valid_d = 1'b0;
            end
         end
         S_DISPENSE: begin
            if (bus.coin_ack) begin
               remaining_d  = remaining_q - WIDTH'(coin_value_q);
               coin_valid_d = 1'b0;
               case (coin_value_q)
                  8'd50:   inv_50_d = inv_50_q - CNT_W'(1'b1);
                  8'd10:   inv_10_d = inv_10_q - CNT_W'(1'b1);
                  8'd5:    inv_5_d  = inv_5_q - CNT_W'(1'b1);
                  8'd1:    inv_1_d  = inv_1_q - CNT_W'(1'b1);
                  default: inv_1_d  = inv_1_q;
               endcase
               if (remaining_d == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_SELECT;
               end
            end else begin
               state_d = S_DISPENSE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_SHORT: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Status flags are registered copies of the state being entered
      done_d  = (state_d == S_DONE) || (state_d == S_SHORT);
      short_d = (state_d == S_SHORT);
      busy_d  = (state_d != S_IDLE);
   end

   assign bus.coin_valid = coin_valid_q;
   assign bus.coin_value = coin_value_q;
   assign bus.remaining  = remaining_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.short      = short_q;
   assign bus.inv_50     = inv_50_q;
   assign bus.inv_10     = inv_10_q;
   assign bus.inv_5      = inv_5_q;
   assign bus.inv_1      = inv_1_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed table, hand-written corner
// sequences and randomized transactions against a greedy payout model.
module tb_change_dispenser;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   change_dispenser_if #(.WIDTH(32), .CNT_W(8)) a_if ();
   change_dispenser_if #(.WIDTH(32), .CNT_W(8)) b_if ();

   change_dispenser #(.WIDTH(32), .CNT_W(8), .INIT_50(8), .INIT_10(20),
                      .INIT_5(20), .INIT_1(50))
      dut_a (.clk(clk), .reset(reset), .bus(a_if.slave));

   change_dispenser #(.WIDTH(32), .CNT_W(8), .INIT_50(1), .INIT_10(0),
                      .INIT_5(0), .INIT_1(3))
      dut_b (.clk(clk), .reset(reset), .bus(b_if.slave));

   typedef struct {
      logic [31:0] chg;
      int          mode;     // 0: ack always high, 1: random ack, 2: stall 5 cycles
      int          ncoins;
      int          first;
      bit          exp_short;
      int          exp_rem;
      int          i50, i10, i5, i1;
   } vec_t;

   int     errors = 0;
   int     checks = 0;
   int     denom[4] = '{50, 10, 5, 1};
   int     init_a[4] = '{8, 20, 20, 50};
   int     m_inv[4];
   int     exp_q[$];
   int     exp_rem;
   int     got_q[$];
   int     first_cyc;
   bit     seen_done, got_short, busy_at_done;
   int     got_rem;
   vec_t   vecs[5];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_inv[i] = init_a[i];
   endtask

   // Greedy payout straight from the rules: largest coin that fits and is in stock
   task automatic model_pay(input logic [31:0] chg);
      int rem;
      rem = int'(chg);
      exp_q.delete();
      for (int i = 0; i < 4; i++) begin
         while (rem >= denom[i] && m_inv[i] > 0) begin
            exp_q.push_back(denom[i]);
            rem -= denom[i];
            m_inv[i]--;
         end
      end
      exp_rem = rem;
   endtask

   task automatic check_inv_a(input int i50, input int i10, input int i5, input int i1);
      check("inv_50", a_if.inv_50, i50);
      check("inv_10", a_if.inv_10, i10);
      check("inv_5", a_if.inv_5, i5);
      check("inv_1", a_if.inv_1, i1);
   endtask

   task automatic run_a(input logic [31:0] chg, input int mode, input bit rf_busy, input bit rf_start);
      int         stall;
      bit         pend;
      logic [7:0] pval;
      logic       ack;
      stall = 0;
      pend = 1'b0;
      pval = 8'd0;
      got_q.delete();
      first_cyc = -1;
      seen_done = 1'b0;
      got_short = 1'b0;
      got_rem = 0;
      busy_at_done = 1'b0;
      a_if.start = 1'b1;
      a_if.change = chg;
      a_if.refill = rf_start;
      tick();
      a_if.start = 1'b0;
      a_if.refill = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         a_if.refill = rf_busy && (cyc < 3);
         if (pend) check("coin_hold", {a_if.coin_valid, a_if.coin_value}, {1'b1, pval});
         if (a_if.done) begin
            seen_done = 1'b1;
            got_short = a_if.short;
            got_rem = int'(a_if.remaining);
            busy_at_done = a_if.busy;
            break;
         end
         case (mode)
            0:       ack = 1'b1;
            2:       ack = (stall >= 5);
            default: ack = 1'($urandom_range(0, 1));
         endcase
         a_if.coin_ack = ack;
         if (a_if.coin_valid) begin
            if (first_cyc < 0) first_cyc = cyc;
            if (stall < 5) stall++;
            if (ack) got_q.push_back(int'(a_if.coin_value));
            pend = !ack;
            pval = a_if.coin_value;
         end else begin
            pend = 1'b0;
         end
         tick();
      end
      a_if.coin_ack = 1'b0;
      a_if.refill = 1'b0;
      if (!seen_done) begin
         check("done_timeout", 0, 1);
      end else begin
         check("busy_at_done", busy_at_done, 1);
         tick();
         check("done_busy_after", {a_if.done, a_if.busy}, 2'b00);
      end
   endtask

   task automatic compare_model();
      check("coin_count", got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         check("coin_order", got_q[i], exp_q[i]);
      check("short", got_short, exp_rem != 0);
      check("remaining", got_rem, exp_rem);
      check_inv_a(m_inv[0], m_inv[1], m_inv[2], m_inv[3]);
      check("first_coin_lat", first_cyc + 1, (exp_q.size() > 0) ? 2 : 0);
   endtask

   initial begin
      bit done_seen;
      vecs[0] = '{chg: 32'd66,  mode: 0, ncoins: 4, first: 50, exp_short: 1'b0, exp_rem: 0, i50: 7, i10: 19, i5: 19, i1: 49};
      vecs[1] = '{chg: 32'd0,   mode: 1, ncoins: 0, first: 0,  exp_short: 1'b0, exp_rem: 0, i50: 7, i10: 19, i5: 19, i1: 49};
      vecs[2] = '{chg: 32'd15,  mode: 2, ncoins: 2, first: 10, exp_short: 1'b0, exp_rem: 0, i50: 7, i10: 18, i5: 18, i1: 49};
      vecs[3] = '{chg: 32'd3,   mode: 1, ncoins: 3, first: 1,  exp_short: 1'b0, exp_rem: 0, i50: 7, i10: 18, i5: 18, i1: 46};
      vecs[4] = '{chg: 32'd120, mode: 1, ncoins: 4, first: 50, exp_short: 1'b0, exp_rem: 0, i50: 5, i10: 16, i5: 18, i1: 46};

      reset = 1'b1;
      a_if.start = 1'b0; a_if.change = '0; a_if.coin_ack = 1'b0; a_if.refill = 1'b0;
      b_if.start = 1'b0; b_if.change = '0; b_if.coin_ack = 1'b0; b_if.refill = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      check("rst_outputs", {a_if.coin_valid, a_if.coin_value, a_if.busy, a_if.done, a_if.short}, 12'd0);
      check("rst_remaining", a_if.remaining, 0);
      check_inv_a(8, 20, 20, 50);
      model_reset();

      // Directed table
      for (int v = 0; v < 5; v++) begin
         model_pay(vecs[v].chg);
         run_a(vecs[v].chg, vecs[v].mode, 1'b0, 1'b0);
         check("tbl_ncoins", got_q.size(), vecs[v].ncoins);
         if (vecs[v].ncoins > 0) check("tbl_first", got_q[0], vecs[v].first);
         check("tbl_short", got_short, vecs[v].exp_short);
         check("tbl_rem", got_rem, vecs[v].exp_rem);
         check_inv_a(vecs[v].i50, vecs[v].i10, vecs[v].i5, vecs[v].i1);
         compare_model();
      end

      // Second start mid-transaction is ignored; reset in DISPENSE abandons it
      a_if.coin_ack = 1'b1;
      a_if.start = 1'b1;
      a_if.change = 32'd66;
      tick();
      a_if.start = 1'b0;
      tick();
      tick();
      a_if.start = 1'b1;
      a_if.change = 32'd99;
      tick();
      a_if.start = 1'b0;
      check("ignored_start", {a_if.coin_valid, a_if.coin_value}, {1'b1, 8'd10});
      check("ignored_start_rem", a_if.remaining, 16);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      a_if.coin_ack = 1'b0;
      check("rst_mid_valid_busy", {a_if.coin_valid, a_if.busy}, 2'b00);
      check_inv_a(8, 20, 20, 50);
      done_seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         done_seen |= a_if.done;
         tick();
      end
      check("rst_no_done", done_seen, 0);
      model_reset();

      // Refill while busy has no effect
      model_pay(32'd37);
      run_a(32'd37, 0, 1'b1, 1'b0);
      compare_model();

      // Small-inventory instance runs short: 50,1,1,1 then short with 2 unpaid
      b_if.coin_ack = 1'b1;
      b_if.start = 1'b1;
      b_if.change = 32'd55;
      tick();
      b_if.start = 1'b0;
      got_q.delete();
      seen_done = 1'b0;
      for (int c = 0; c < 100 && !seen_done; c++) begin
         if (b_if.done) begin
            seen_done = 1'b1;
            got_short = b_if.short;
            got_rem = int'(b_if.remaining);
         end else begin
            if (b_if.coin_valid) got_q.push_back(int'(b_if.coin_value));
            tick();
         end
      end
      b_if.coin_ack = 1'b0;
      check("b_done_seen", seen_done, 1);
      check("b_ncoins", got_q.size(), 4);
      if (got_q.size() == 4)
         check("b_coins", {got_q[0][7:0], got_q[1][7:0], got_q[2][7:0], got_q[3][7:0]},
               {8'd50, 8'd1, 8'd1, 8'd1});
      check("b_short", got_short, 1);
      check("b_rem", got_rem, 2);
      check("b_inv_empty", {b_if.inv_50, b_if.inv_10, b_if.inv_5, b_if.inv_1}, 32'd0);
      tick();
      b_if.refill = 1'b1;
      tick();
      b_if.refill = 1'b0;
      check("b_refill", {b_if.inv_50, b_if.inv_10, b_if.inv_5, b_if.inv_1},
            {8'd1, 8'd0, 8'd0, 8'd3});

      // Randomized transactions against the greedy model
      for (int t = 0; t < 40; t++) begin
         logic [31:0] chg;
         bit rfb, rfs;
         if ($urandom_range(0, 4) == 0) begin
            a_if.refill = 1'b1;
            tick();
            a_if.refill = 1'b0;
            model_reset();
            check_inv_a(8, 20, 20, 50);
         end
         chg = 32'($urandom_range(0, 180));
         rfb = ($urandom_range(0, 5) == 0);
         rfs = ($urandom_range(0, 5) == 0);
         model_pay(chg);
         run_a(chg, 1, rfb, rfs);
         compare_model();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Returns change to the customer after a ticket sale, one coin at a time. It receives a change amount from the ticket vending machine and pays it out greedily in 50/10/5/1 coins to a coin-ejection mechanism through a valid/ack handshake. It keeps a per-denomination coin inventory and reports when it cannot pay the full amount.

## Interface
- WIDTH, 32, width of the change amount and the remaining amount
- CNT_W, 8, width of each inventory counter
- INIT_50, 8, number of 50 coins loaded on reset or refill
- INIT_10, 20, number of 10 coins loaded on reset or refill
- INIT_5, 20, number of 5 coins loaded on reset or refill
- INIT_1, 50, number of 1 coins loaded on reset or refill

- clk  in  1  single clock; all logic on the rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request to pay `change`; sampled only in IDLE
- change  in  WIDTH  amount to return; captured on an accepted start
- coin_ack  in  1  mechanism has taken the presented coin
- refill  in  1  reload all inventories to their INIT_* values; honoured only in IDLE
- coin_valid  out  1  a coin is presented on coin_value
- coin_value  out  8  denomination presented: 50, 10, 5 or 1
- remaining  out  WIDTH  amount still unpaid
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at the end of every transaction
- short  out  1  one-cycle pulse, together with done, when the full change could not be paid
- inv_50, inv_10, inv_5, inv_1  out  CNT_W each  current inventory counts

## Operation
- Reset values: coin_valid=0, coin_value=0, remaining=0, busy=0, done=0, short=0, state=IDLE, inv_*=INIT_*.
- States: IDLE, SELECT, DISPENSE, DONE, SHORT.
- **IDLE**
  - start=1 and change=0: go to DONE.
  - start=1 and change≠0: remaining<=change, go to SELECT.
  - refill=1 with start=0: inv_*<=INIT_*.
  - start and refill both high: start wins and refill is dropped.
- **SELECT**
  - Pick the largest d in {50,10,5,1} with d<=remaining and inv_d>0.
  - If found: coin_value<=d, coin_valid<=1, go to DISPENSE.
  - If none found: go to SHORT.
- **DISPENSE**
  - coin_valid and coin_value stay stable until coin_ack=1.
  - On an edge with coin_ack=1: remaining<=remaining−d, inv_d<=inv_d−1, coin_valid<=0.
  - After that edge: go to DONE if the new remaining is 0, otherwise go to SELECT.
  - coin_ack outside DISPENSE is ignored.
- **DONE**: done=1 for one cycle, then IDLE.
- **SHORT**: done=1 and short=1 for one cycle, then IDLE. remaining holds the unpaid amount until the next accepted start.
- start and refill while busy are ignored (not queued).
- An inventory counter never underflows, because a denomination is only selected when its count is >0.
- Greedy order is mandatory. No backtracking is done, even if a non-greedy payout would have succeeded.
- Subtraction is WIDTH-bit unsigned. It cannot wrap, because d<=remaining is guaranteed at selection.
- reset in any state, including DISPENSE with coin_valid=1:
  - at the next edge, state=IDLE and coin_valid=0;
  - inventories return to INIT_*;
  - the partially paid transaction is abandoned and no done pulse is produced.

## Timing
- done and short are registered outputs, valid the cycle after the state transition.
- start accepted at edge N: state=SELECT after N. coin_valid=1 after edge N+1, so the first coin appears 2 cycles after start.
- Per coin with coin_ack held high: coin_valid is high for 1 cycle and low for 1 cycle (SELECT), giving one coin every 2 cycles.
- Last coin acked at edge M: done=1 during the cycle after M, busy=0 after M+1.
- change=0 accepted at edge N: done=1 during the cycle after N, and coin_valid never rises.
- Running out of coins: from SELECT, done=1 and short=1 appear one cycle later.
- busy rises the cycle after start is accepted and falls the cycle after the done pulse.

## Test plan
1. After reset, start with change=66 and coin_ack always 1:
   - coins presented in order 50, 10, 5, 1;
   - done=1, short=0, remaining=0;
   - inv = 7/19/19/49;
   - first coin_valid two cycles after start.
2. start with change=0: done pulses the next cycle, coin_valid stays 0, inventories unchanged.
3. start with change=15, coin_ack held low for 5 cycles and then driven high:
   - coin_valid=1 with coin_value=10 stays stable for all 5 cycles;
   - the next coin is 5, then done.
4. Instance with INIT_50=1, INIT_10=0, INIT_5=0, INIT_1=3, start with change=55:
   - coins 50, 1, 1, 1;
   - then done=1, short=1, remaining=2, all inventories 0.
5. During test 1, assert start with change=99 mid-transaction, then assert reset while in DISPENSE:
   - the second start is ignored;
   - after reset, coin_valid=0, busy=0, inv=INIT_*, and no done pulse occurs.
6. Drain inventories with test 4, then pulse refill in IDLE: inv=INIT_* on the next cycle. A refill pulsed while busy has no effect.
